if_id_stage: RTL and testbench

- Instruction-fetch stage: PC register plus IF/ID pipeline register, with load-use hazard detection, stall and branch-flush control.
- Drives the instruction-memory address and feeds the decode stage; the decode stage in turn feeds the ID/EX register.
- Generates the bubble request that makes decode inject zeroed control bits into ID/EX.

---
 rtl/if_id_stage_if.sv | 47 ++++
 rtl/if_id_stage.sv | 97 +++++++++
 tb/tb_if_id_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
// ---------------------------------------------------------------------------
// if_id_stage_if
// Groups every non-clock, non-reset signal of the fetch stage.
//   master : the fetch stage itself (if_id_stage)
//   slave  : the surrounding pipeline (instruction memory, decode, ID/EX)
// Signals:
//   Instr        imem -> stage   instruction word at PcOut (combinational read)
//   StallIn      pipe -> stage   later-stage freeze request
//   BranchTaken  dec  -> stage   branch/jump resolved taken in decode
//   BranchTarget dec  -> stage   redirect address
//   IdExMemRead  idex -> stage   MemRead of the instruction in ID/EX
//   IdExRtAddr   idex -> stage   Rt address of the instruction in ID/EX
//   PcOut        stage -> imem   current fetch address
//   InstrOut     stage -> dec    IF/ID instruction register
//   PcPlus4Out   stage -> dec    IF/ID copy of fetch PC + 4
//   ValidOut     stage -> dec    IF/ID holds a real instruction
//   BubbleOut    stage -> dec    zero control fields into ID/EX this cycle
//   StallCount   stage -> perf   stall cycle counter
//   FlushCount   stage -> perf   branch flush counter
// ---------------------------------------------------------------------------
interface if_id_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      Instr;
    logic             StallIn;
    logic             BranchTaken;
    logic [31:0]      BranchTarget;
    logic             IdExMemRead;
    logic [4:0]       IdExRtAddr;
    logic [31:0]      PcOut;
    logic [31:0]      InstrOut;
    logic [31:0]      PcPlus4Out;
    logic             ValidOut;
    logic             BubbleOut;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        input  Instr, StallIn, BranchTaken, BranchTarget, IdExMemRead, IdExRtAddr,
        output PcOut, InstrOut, PcPlus4Out, ValidOut, BubbleOut, StallCount, FlushCount
    );

    modport slave (
        output Instr, StallIn, BranchTaken, BranchTarget, IdExMemRead, IdExRtAddr,
        input  PcOut, InstrOut, PcPlus4Out, ValidOut, BubbleOut, StallCount, FlushCount
    );
endinterface

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// Instruction-fetch stage: PC register and IF/ID pipeline register with
// load-use hazard detection, stall hold and branch flush.
// Ports:
//   clk    pipeline clock, all state updates on posedge
//   reset  asynchronous, active-high reset
//   bus    if_id_stage_if.master (fetch/decode/hazard signals)
// Parameters:
//   RESET_PC  PC value loaded on reset
//   CNT_W     performance counter width
// Configuration:
//   IF_ID_PERF_CNT_EN  when defined, builds saturating StallCount/FlushCount;
//                      otherwise both counters are tied to zero.
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    if_id_stage_if.master   bus
);
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    logic [31:0] pc_plus4;
    logic        hazard;
    logic        stall;

    assign pc_plus4 = pc_q + 32'd4;   // wraps modulo 2^32

    // Conservative load-use check: compare against both source fields
    // without decoding the opcode. A squashed slot never causes a hazard.
    assign hazard = bus.IdExMemRead && (bus.IdExRtAddr != 5'd0) && valid_q &&
                    ((bus.IdExRtAddr == instr_q[25:21]) ||
                     (bus.IdExRtAddr == instr_q[20:16]));

    assign stall = hazard || bus.StallIn;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else if (stall) begin
            // Hold everything; a taken branch in decode re-resolves after release.
            pc_q       <= pc_q;
        end else if (bus.BranchTaken) begin
            // Squash the instruction fetched behind the branch (no delay slot).
            pc_q       <= bus.BranchTarget;
            instr_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_plus4;
            instr_q    <= bus.Instr;
            pc_plus4_q <= pc_plus4;
            valid_q    <= 1'b1;
        end
    end

    assign bus.PcOut      = pc_q;
    assign bus.InstrOut   = instr_q;
    assign bus.PcPlus4Out = pc_plus4_q;
    assign bus.ValidOut   = valid_q;
    assign bus.BubbleOut  = hazard;   // follows the load-use hazard only, not StallIn

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (!stall && bus.BranchTaken && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.StallCount = stall_cnt;
    assign bus.FlushCount = flush_cnt;
`else
    assign bus.StallCount = {CNT_W{1'b0}};
    assign bus.FlushCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
// Directed self-checking bench for if_id_stage with RESET_PC = 0x0040_0000.
// Inputs change 1 time unit after a posedge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_if_id_stage;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          CW     = 16;
`ifdef IF_ID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    if_id_stage_if #(.CNT_W(CW)) bus ();

    if_id_stage #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counter expectation: real count with the feature built, zero otherwise.
    function automatic logic [31:0] cnt(input int n);
        return PERF ? n : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pp4, input logic vld);
        check({tag, ".pc"},    bus.PcOut,      pc);
        check({tag, ".instr"}, bus.InstrOut,   ins);
        check({tag, ".pc4"},   bus.PcPlus4Out, pp4);
        check({tag, ".valid"}, {31'd0, bus.ValidOut}, {31'd0, vld});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.Instr = 32'h2008_0005;
        bus.StallIn = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.BranchTarget = 32'd0;
        bus.IdExMemRead = 1'b0;
        bus.IdExRtAddr = 5'd0;
        #1;
        check_regs("reset", RST_PC, 32'd0, 32'd0, 1'b0);
        check("reset.scnt", bus.StallCount, 32'd0);
        check("reset.fcnt", bus.FlushCount, 32'd0);
        #11 reset = 1'b0;   // released between edges

        // Sequential fetch
        step();
        check_regs("fetch1", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1);
        bus.Instr = 32'h0109_5020;   // add $10,$8,$9 (rs=8, rt=9)
        step();
        check("fetch2.pc", bus.PcOut, 32'h0040_0008);
        step();
        check_regs("fetch3", 32'h0040_000C, 32'h0109_5020, 32'h0040_000C, 1'b1);

        // Load-use on rs
        bus.IdExMemRead = 1'b1;
        bus.IdExRtAddr = 5'd8;
        #1;
        check("lu.bubble", {31'd0, bus.BubbleOut}, 32'd1);
        bus.Instr = 32'h8D0B_0004;   // lw $11,4($8)
        step();
        check_regs("lu.hold", 32'h0040_000C, 32'h0109_5020, 32'h0040_000C, 1'b1);
        bus.IdExMemRead = 1'b0;
        #1;
        check("lu.clear", {31'd0, bus.BubbleOut}, 32'd0);
        step();
        check_regs("lu.resume", 32'h0040_0010, 32'h8D0B_0004, 32'h0040_0010, 1'b1);
        check("lu.scnt", bus.StallCount, cnt(1));

        // Rt address zero never hazards
        bus.Instr = 32'h2008_0005;
        step();
        bus.IdExMemRead = 1'b1;
        bus.IdExRtAddr = 5'd0;
        #1;
        check("rt0.bubble", {31'd0, bus.BubbleOut}, 32'd0);
        step();
        check("rt0.pc", bus.PcOut, 32'h0040_0018);
        bus.IdExMemRead = 1'b0;

        // Branch flush
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 32'h0040_0100;
        step();
        check_regs("br", 32'h0040_0100, 32'd0, 32'd0, 1'b0);
        check("br.fcnt", bus.FlushCount, cnt(1));
        bus.BranchTaken = 1'b0;
        bus.Instr = 32'h0109_5020;
        step();
        check_regs("br.next", 32'h0040_0104, 32'h0109_5020, 32'h0040_0104, 1'b1);

        // Hazard (rt match) with a taken branch: hold, no redirect
        bus.IdExMemRead = 1'b1;
        bus.IdExRtAddr = 5'd9;
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 32'h0040_0200;
        #1;
        check("hzbr.bubble", {31'd0, bus.BubbleOut}, 32'd1);
        step();
        check_regs("hzbr.hold", 32'h0040_0104, 32'h0109_5020, 32'h0040_0104, 1'b1);
        check("hzbr.fcnt", bus.FlushCount, cnt(1));
        bus.IdExMemRead = 1'b0;
        step();
        check_regs("hzbr.redir", 32'h0040_0200, 32'd0, 32'd0, 1'b0);
        check("hzbr.scnt", bus.StallCount, cnt(2));
        check("hzbr.fcnt2", bus.FlushCount, cnt(2));

        // External stall alone: holds PC, no bubble, branch ignored
        bus.StallIn = 1'b1;
        bus.BranchTarget = 32'h0040_0300;
        #1;
        check("ext.bubble", {31'd0, bus.BubbleOut}, 32'd0);
        step();
        check("ext.pc", bus.PcOut, 32'h0040_0200);
        check("ext.scnt", bus.StallCount, cnt(3));
        bus.StallIn = 1'b0;
        bus.BranchTaken = 1'b0;
        step();
        check("ext.resume", bus.PcOut, 32'h0040_0204);

        // StallIn and hazard together count once
        bus.StallIn = 1'b1;
        bus.IdExMemRead = 1'b1;
        bus.IdExRtAddr = 5'd8;
        #1;
        check("both.bubble", {31'd0, bus.BubbleOut}, 32'd1);
        step();
        check("both.pc", bus.PcOut, 32'h0040_0204);
        check("both.scnt", bus.StallCount, cnt(4));
        bus.StallIn = 1'b0;
        bus.IdExMemRead = 1'b0;

        // PC wrap
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 32'hFFFF_FFFC;
        step();
        check("wrap.tgt", bus.PcOut, 32'hFFFF_FFFC);
        bus.BranchTaken = 1'b0;
        bus.Instr = 32'h2008_0005;
        step();
        check_regs("wrap", 32'h0000_0000, 32'h2008_0005, 32'h0000_0000, 1'b1);
        check("wrap.fcnt", bus.FlushCount, cnt(3));

        // Asynchronous reset in the middle of a stall
        bus.StallIn = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        check_regs("arst", RST_PC, 32'd0, 32'd0, 1'b0);
        check("arst.scnt", bus.StallCount, 32'd0);
        check("arst.fcnt", bus.FlushCount, 32'd0);
        bus.StallIn = 1'b0;
        step();
        #2 reset = 1'b0;
        step();
        check_regs("arst.rel", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
